// File: rtl/pixel_stream_if.sv
// Pixel stream, classification decision and result-log signals between the
// feeder and the CNN datapath / result sink.
interface pixel_stream_if #(
    parameter int DATA_BITS  = 8,
    parameter int CLASS_BITS = 4,
    parameter int IDX_BITS   = 1
);
    logic [DATA_BITS-1:0]  pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_last;
    logic [CLASS_BITS-1:0] dec_in;
    logic                  dec_valid;
    logic                  res_wr;
    logic [IDX_BITS-1:0]   res_idx;
    logic [CLASS_BITS-1:0] res_class;

    // Feeder side: drives pixels and result log, consumes ready and decisions.
    modport master (
        output pix_data, pix_valid, pix_last, res_wr, res_idx, res_class,
        input  pix_ready, dec_in, dec_valid
    );

    // Datapath / logger side.
    modport slave (
        input  pix_data, pix_valid, pix_last, res_wr, res_idx, res_class,
        output pix_ready, dec_in, dec_valid
    );
endinterface

// File: rtl/pixel_stream_feeder.sv
// Batch sequencer: streams NUM_IMG images from internal RAM one pixel per
// accepted handshake, waits for each decision (with timeout) and logs it.
module pixel_stream_feeder #(
    parameter int DATA_BITS  = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int NUM_IMG    = 4,
    parameter int CLASS_BITS = 4,
    parameter int TIMEOUT    = 4095,
    parameter int ADDR_BITS  = $clog2(NUM_IMG * IMG_W * IMG_H),
    parameter int IDX_BITS   = ($clog2(NUM_IMG) > 0) ? $clog2(NUM_IMG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 done,
    pixel_stream_if.master       ps
);
    localparam int PIX       = IMG_W * IMG_H;
    localparam int DEPTH     = NUM_IMG * PIX;
    localparam int PIX_BITS  = ($clog2(PIX) > 0) ? $clog2(PIX) : 1;
    localparam int WAIT_BITS = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PIX_BITS-1:0]  PIX_LAST = PIX_BITS'(PIX - 1);
    localparam logic [IDX_BITS-1:0]  IMG_LAST = IDX_BITS'(NUM_IMG - 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, PREFETCH, STREAM, WAIT_RES, LOG, FIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;   // next RAM address to fetch
    logic [PIX_BITS-1:0]   pix_q, pix_d;           // index of pixel on the bus
    logic [IDX_BITS-1:0]   img_q, img_d;
    logic [WAIT_BITS-1:0]  wait_q, wait_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [CLASS_BITS-1:0] res_class_q, res_class_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  rd_en;
    logic                  xfer;
    logic [DATA_BITS-1:0]  rd_data_q;
    logic [DATA_BITS-1:0]  ram_q [DEPTH];

    assign xfer = pix_valid_q && ps.pix_ready;

    // Next-state logic. The running read address walks straight through the
    // images, so each image base falls out of the increment with no multiply.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        pix_d         = pix_q;
        img_d         = img_q;
        wait_d        = wait_q;
        pix_valid_d   = pix_valid_q;
        res_class_d   = res_class_q;
        timeout_err_d = timeout_err_q;
        rd_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = PREFETCH;
                    timeout_err_d = 1'b0;
                    img_d         = '0;
                    pix_d         = '0;
                    rd_addr_d     = '0;
                end
            end
            PREFETCH: begin
                rd_en       = 1'b1;
                rd_addr_d   = rd_addr_q + ADDR_BITS'(1);
                pix_valid_d = 1'b1;
                state_d     = STREAM;
            end
            STREAM: begin
                if (xfer) begin
                    if (pix_q == PIX_LAST) begin
                        pix_valid_d = 1'b0;
                        pix_d       = '0;
                        wait_d      = '0;
                        state_d     = WAIT_RES;
                    end else begin
                        // fetch the following pixel while this one is accepted
                        rd_en     = 1'b1;
                        rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                        pix_d     = pix_q + PIX_BITS'(1);
                    end
                end
            end
            WAIT_RES: begin
                wait_d = wait_q + WAIT_BITS'(1);
                if (ps.dec_valid) begin
                    res_class_d = ps.dec_in;
                    state_d     = LOG;
                end else if (wait_d == WAIT_MAX) begin
                    res_class_d   = '1;
                    timeout_err_d = 1'b1;
                    state_d       = LOG;
                end
            end
            LOG: begin
                if (img_q == IMG_LAST) begin
                    state_d = FIN;
                end else begin
                    img_d   = img_q + IDX_BITS'(1);
                    state_d = PREFETCH;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            pix_q         <= '0;
            img_q         <= '0;
            wait_q        <= '0;
            pix_valid_q   <= 1'b0;
            res_class_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            pix_q         <= pix_d;
            img_q         <= img_d;
            wait_q        <= wait_d;
            pix_valid_q   <= pix_valid_d;
            res_class_q   <= res_class_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Pixel RAM: loads only while idle; read register advances only on fetch,
    // which keeps pix_data stable across a stall.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) ram_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= ram_q[rd_addr_q];
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign timeout_err  = timeout_err_q;
    assign ps.pix_valid = pix_valid_q;
    assign ps.pix_data  = pix_valid_q ? rd_data_q : '0;
    assign ps.pix_last  = pix_valid_q && (pix_q == PIX_LAST);
    assign ps.res_wr    = (state_q == LOG);
    assign ps.res_idx   = img_q;
    assign ps.res_class = res_class_q;
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Randomised bench for pixel_stream_feeder: a 4x4x2 instance for the batch
// scenarios and a 28x28x1 instance for full-size geometry.
module tb_pixel_stream_feeder;
    localparam int DW = 8, W = 4, H = 4, NI = 2, CB = 4, TO = 20;
    localparam int PIX = W * H, DEPTH = NI * PIX, AB = $clog2(DEPTH), IB = 1;
    localparam int BPIX = 784, BAB = $clog2(BPIX);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en, start, busy, timeout_err, done;
    logic [AB-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    pixel_stream_if #(.DATA_BITS(DW), .CLASS_BITS(CB), .IDX_BITS(IB)) ps();
    pixel_stream_feeder #(.DATA_BITS(DW), .IMG_W(W), .IMG_H(H), .NUM_IMG(NI),
                          .CLASS_BITS(CB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .timeout_err(timeout_err), .done(done), .ps(ps));

    logic           b_wr_en, b_start, b_busy, b_te, b_done;
    logic [BAB-1:0] b_wr_addr;
    logic [DW-1:0]  b_wr_data;
    pixel_stream_if #(.DATA_BITS(DW), .CLASS_BITS(CB), .IDX_BITS(1)) pb();
    pixel_stream_feeder #(.DATA_BITS(DW), .IMG_W(28), .IMG_H(28), .NUM_IMG(1),
                          .CLASS_BITS(CB), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .busy(b_busy), .timeout_err(b_te), .done(b_done), .ps(pb));

    int n_cmp = 0, n_bad = 0;

    // reference model state: RAM image and the per-image decision policy
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] bshadow [BPIX];
    int            dec_delay [NI];
    logic [CB-1:0] dec_cls [NI];
    bit            dec_on, inject;
    int            ready_mode;

    // observations from the last batch
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc [$];
    int            r_idx [$], r_gap [$], r_cyc [$];
    logic [CB-1:0] r_cls [$];
    bit            r_te [$];
    int            done_cyc, stall_bad, te_at_busy, res_in_stream;
    bit            timed_out;

    // A decision d cycles after the final transfer is honoured for d<=TO;
    // otherwise the timeout fires TO cycles after the final transfer. LOG is
    // observed one cycle after the deciding edge.
    function automatic logic [CB-1:0] exp_cls(input int r);
        return (dec_on && dec_delay[r] <= TO) ? dec_cls[r] : {CB{1'b1}};
    endfunction
    function automatic int exp_gap(input int r);
        return (dec_on && dec_delay[r] <= TO) ? dec_delay[r] + 1 : TO + 1;
    endfunction

    task automatic load_ram(input bit rnd);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AB'(a);
            wr_data = rnd ? DW'($urandom) : DW'(a);
            shadow[a] = wr_data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drive one batch on the small instance and record what comes out.
    task automatic run_batch();
        int cyc = 0, pat = 0, nlast = 0, last_cyc = 0, dec_at = -1, dec_img = 0;
        bit prev_stall = 0, injected = 0, r = 0;
        logic [DW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        r_idx.delete(); r_gap.delete(); r_cyc.delete(); r_cls.delete(); r_te.delete();
        done_cyc = -1; stall_bad = 0; te_at_busy = -1; res_in_stream = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1; ps.pix_ready = 1'b0; ps.dec_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_en = 1'b0; ps.dec_valid = 1'b0;
            if (busy && te_at_busy < 0) te_at_busy = int'(timeout_err);
            if (prev_stall && ps.pix_valid && (ps.pix_data !== prev_d || ps.pix_last !== prev_l))
                stall_bad++;
            if (ps.res_wr) begin
                r_idx.push_back(int'(ps.res_idx)); r_cls.push_back(ps.res_class);
                r_gap.push_back(cyc - last_cyc); r_te.push_back(timeout_err); r_cyc.push_back(cyc);
                if (nlast == 0) res_in_stream++;
            end
            if (done) begin done_cyc = cyc; break; end
            if (cyc > 3000) begin timed_out = 1; break; end
            if (dec_on && cyc == dec_at) begin ps.dec_valid = 1'b1; ps.dec_in = dec_cls[dec_img]; end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (pat % 4 == 0) || (pat % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pat++;
            ps.pix_ready = r;
            if (ps.pix_valid && r) begin
                got_data.push_back(ps.pix_data); got_last.push_back(ps.pix_last); got_cyc.push_back(cyc);
                if (ps.pix_last) begin
                    last_cyc = cyc;
                    if (nlast < NI) begin dec_img = nlast; dec_at = cyc + dec_delay[nlast]; end
                    nlast++;
                end
            end
            if (inject && !injected && got_data.size() == 5) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = AB'(3); wr_data = ~shadow[3];
                ps.dec_valid = 1'b1; ps.dec_in = 4'd5; injected = 1;
            end
            prev_stall = ps.pix_valid && !r; prev_d = ps.pix_data; prev_l = ps.pix_last;
        end
        ps.pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, ps.pix_valid, ps.pix_last, ps.res_wr, timeout_err, done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b want=000000",
                {busy, ps.pix_valid, ps.pix_last, ps.res_wr, timeout_err, done});
        end
        n_cmp++;
        if (ps.pix_data !== '0) begin n_bad++; $display("FAIL reset_pix_data got=%0h want=0", ps.pix_data); end
        n_cmp++;
        if ({ps.res_idx, ps.res_class} !== '0) begin
            n_bad++; $display("FAIL reset_res got=%0h/%0h want=0/0", ps.res_idx, ps.res_class);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_ram(0);
        ready_mode = 0; dec_on = 1; inject = 0;
        dec_delay = '{5, 5}; dec_cls = '{4'd3, 4'd7};
        run_batch();
        n_cmp++;
        if (timed_out || got_data.size() != DEPTH) begin
            n_bad++; $display("FAIL basic_count got=%0d want=%0d", got_data.size(), DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (got_data[i] !== shadow[i] || got_last[i] !== (i % PIX == PIX - 1)) begin
                n_bad++; $display("FAIL basic_pix[%0d] got=%0h/%0b want=%0h/%0b", i, got_data[i],
                    got_last[i], shadow[i], (i % PIX == PIX - 1));
            end
        end
        if (got_cyc.size() == DEPTH) begin
            n_cmp++;
            if (got_cyc[0] !== 2) begin n_bad++; $display("FAIL basic_first_lat got=%0d want=2", got_cyc[0]); end
            n_cmp++;
            if (got_cyc[PIX-1] - got_cyc[0] !== PIX - 1 || got_cyc[DEPTH-1] - got_cyc[PIX] !== PIX - 1) begin
                n_bad++; $display("FAIL basic_bubbles got=%0d,%0d want=%0d", got_cyc[PIX-1] - got_cyc[0],
                    got_cyc[DEPTH-1] - got_cyc[PIX], PIX - 1);
            end
        end
        n_cmp++;
        if (r_idx.size() != NI) begin n_bad++; $display("FAIL basic_res_count got=%0d want=%0d", r_idx.size(), NI); end
        for (int r = 0; r < r_idx.size() && r < NI; r++) begin
            n_cmp++;
            if (r_idx[r] !== r || r_cls[r] !== exp_cls(r) || r_gap[r] !== exp_gap(r)) begin
                n_bad++; $display("FAIL basic_res[%0d] got=%0d/%0h/%0d want=%0d/%0h/%0d", r, r_idx[r],
                    r_cls[r], r_gap[r], r, exp_cls(r), exp_gap(r));
            end
        end
        if (r_cyc.size() == NI) begin
            n_cmp++;
            if (done_cyc - r_cyc[NI-1] !== 1) begin
                n_bad++; $display("FAIL basic_done_lag got=%0d want=1", done_cyc - r_cyc[NI-1]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, timeout_err} !== 3'b000) begin
            n_bad++; $display("FAIL basic_after_done got=%b want=000", {busy, done, timeout_err});
        end
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            load_ram(1);
            ready_mode = m; dec_on = 1; inject = 0;
            dec_delay = '{$urandom_range(1, 10), $urandom_range(1, 10)};
            dec_cls = '{4'($urandom_range(0, 14)), 4'($urandom_range(0, 14))};
            run_batch();
            n_cmp++;
            if (timed_out || got_data.size() != DEPTH) begin
                n_bad++; $display("FAIL bp%0d_count got=%0d want=%0d", m, got_data.size(), DEPTH);
            end
            for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
                n_cmp++;
                if (got_data[i] !== shadow[i] || got_last[i] !== (i % PIX == PIX - 1)) begin
                    n_bad++; $display("FAIL bp%0d_pix[%0d] got=%0h want=%0h", m, i, got_data[i], shadow[i]);
                end
            end
            n_cmp++;
            if (stall_bad !== 0) begin n_bad++; $display("FAIL bp%0d_stall_hold got=%0d want=0", m, stall_bad); end
            for (int r = 0; r < r_idx.size() && r < NI; r++) begin
                n_cmp++;
                if (r_idx[r] !== r || r_cls[r] !== exp_cls(r) || r_gap[r] !== exp_gap(r)) begin
                    n_bad++; $display("FAIL bp%0d_res[%0d] got=%0d/%0h/%0d want=%0d/%0h/%0d", m, r,
                        r_idx[r], r_cls[r], r_gap[r], r, exp_cls(r), exp_gap(r));
                end
            end
        end
    endtask

    task automatic test_timeout();
        ready_mode = 0; dec_on = 0; inject = 0;
        run_batch();
        n_cmp++;
        if (timed_out || done_cyc < 0 || r_idx.size() != NI) begin
            n_bad++; $display("FAIL to_batch got=%0d results want=%0d", r_idx.size(), NI);
        end
        for (int r = 0; r < r_idx.size() && r < NI; r++) begin
            n_cmp++;
            if (r_idx[r] !== r || r_cls[r] !== 4'hF || r_gap[r] !== TO + 1 || r_te[r] !== 1'b1) begin
                n_bad++; $display("FAIL to_res[%0d] got=%0d/%0h/%0d/%0b want=%0d/f/%0d/1", r, r_idx[r],
                    r_cls[r], r_gap[r], r_te[r], r, TO + 1);
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b want=1", timeout_err); end
        dec_on = 1; dec_delay = '{2, 3}; dec_cls = '{4'd1, 4'd2};
        run_batch();
        n_cmp++;
        if (te_at_busy !== 0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL to_clear got=%0d/%b want=0/0", te_at_busy, timeout_err);
        end
    endtask

    task automatic test_coincide();
        ready_mode = 0; dec_on = 1; inject = 0;
        dec_delay = '{TO, TO + 1}; dec_cls = '{4'd9, 4'd6};
        run_batch();
        for (int r = 0; r < r_idx.size() && r < NI; r++) begin
            n_cmp++;
            if (r_cls[r] !== exp_cls(r) || r_gap[r] !== exp_gap(r)) begin
                n_bad++; $display("FAIL coin_res[%0d] got=%0h/%0d want=%0h/%0d", r, r_cls[r], r_gap[r],
                    exp_cls(r), exp_gap(r));
            end
        end
        n_cmp++;
        if (r_te.size() != NI || r_te[0] !== 1'b0 || timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL coin_err got=%0d results te_end=%b want=%0d/1", r_te.size(), timeout_err, NI);
        end
    endtask

    task automatic test_ignored();
        ready_mode = 0; dec_on = 1; inject = 1;
        dec_delay = '{4, 6}; dec_cls = '{4'd11, 4'd12};
        run_batch();
        inject = 0;
        n_cmp++;
        if (timed_out || got_data.size() != DEPTH || res_in_stream !== 0) begin
            n_bad++; $display("FAIL ign_stream got=%0d xfers/%0d early res want=%0d/0", got_data.size(),
                res_in_stream, DEPTH);
        end
        n_cmp++;
        if (r_idx.size() != NI || r_cls[0] !== 4'd11 || r_idx[0] !== 0) begin
            n_bad++; $display("FAIL ign_res got=%0d results want=%0d with first class b", r_idx.size(), NI);
        end
        run_batch();
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (got_data[i] !== shadow[i]) begin
                n_bad++; $display("FAIL ign_ram[%0d] got=%0h want=%0h", i, got_data[i], shadow[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nx = 0, cyc = 0;
        bit ok = 0;
        @(negedge clk);
        start = 1'b1; ps.pix_ready = 1'b0; ps.dec_valid = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++; start = 1'b0;
            if (ps.pix_valid) begin
                if (nx < 9) begin ps.pix_ready = 1'b1; nx++; end
                else begin ps.pix_ready = 1'b0; ok = 1; break; end
            end else ps.pix_ready = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || ps.pix_data !== shadow[9] || ps.pix_valid !== 1'b1) begin
            n_bad++; $display("FAIL rmid_stall got=%0h want=%0h", ps.pix_data, shadow[9]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, ps.pix_valid, ps.pix_last, ps.res_wr, timeout_err, done, ps.pix_data, ps.res_idx,
             ps.res_class} !== '0) begin
            n_bad++; $display("FAIL rmid_async got busy=%b valid=%b data=%0h want all 0", busy, ps.pix_valid,
                ps.pix_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 2; dec_on = 1; dec_delay = '{3, 3}; dec_cls = '{4'd4, 4'd5};
        run_batch();
        n_cmp++;
        if (timed_out || got_data.size() != DEPTH) begin
            n_bad++; $display("FAIL rmid_restream got=%0d want=%0d", got_data.size(), DEPTH);
        end
        for (int i = 0; i < got_data.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (got_data[i] !== shadow[i]) begin
                n_bad++; $display("FAIL rmid_pix[%0d] got=%0h want=%0h", i, got_data[i], shadow[i]);
            end
        end
    endtask

    task automatic test_big();
        int nx = 0, nlast = 0, last_pos = -1, last_at = -1, nres = 0, ridx = -1, cyc = 0, bad = 0;
        logic [CB-1:0] rcls = '0;
        bit dn = 0, r;
        for (int a = 0; a < BPIX; a++) begin
            @(negedge clk);
            b_wr_en = 1'b1; b_wr_addr = BAB'(a); b_wr_data = DW'($urandom); bshadow[a] = b_wr_data;
        end
        @(negedge clk);
        b_wr_en = 1'b0; b_start = 1'b1;
        while (!dn && cyc < 5000) begin
            @(negedge clk);
            cyc++; b_start = 1'b0; pb.dec_valid = 1'b0;
            if (pb.res_wr) begin nres++; ridx = int'(pb.res_idx); rcls = pb.res_class; end
            if (b_done) dn = 1;
            if (last_at >= 0 && cyc == last_at + 3) begin pb.dec_valid = 1'b1; pb.dec_in = 4'd2; end
            r = ($urandom_range(0, 3) != 0);
            pb.pix_ready = r;
            if (pb.pix_valid && r) begin
                if (nx >= BPIX || pb.pix_data !== bshadow[nx]) bad++;
                nx++;
                if (pb.pix_last) begin nlast++; last_pos = nx; last_at = cyc; end
            end
        end
        pb.pix_ready = 1'b0;
        n_cmp++;
        if (!dn || nx !== BPIX || bad !== 0) begin
            n_bad++; $display("FAIL big_stream got=%0d xfers %0d bad done=%b want=%0d/0/1", nx, bad, dn, BPIX);
        end
        n_cmp++;
        if (nlast !== 1 || last_pos !== BPIX) begin
            n_bad++; $display("FAIL big_last got=%0d at %0d want=1 at %0d", nlast, last_pos, BPIX);
        end
        n_cmp++;
        if (nres !== 1 || ridx !== 0 || rcls !== 4'd2) begin
            n_bad++; $display("FAIL big_res got=%0d/%0d/%0h want=1/0/2", nres, ridx, rcls);
        end
    endtask

    initial begin
        wr_en = 0; wr_addr = '0; wr_data = '0; start = 0;
        ps.pix_ready = 0; ps.dec_valid = 0; ps.dec_in = '0;
        b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_start = 0;
        pb.pix_ready = 0; pb.dec_valid = 0; pb.dec_in = '0;
        dec_on = 0; inject = 0; ready_mode = 0;
        dec_delay = '{5, 5}; dec_cls = '{4'd0, 4'd0};
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_coincide();
        test_ignored();
        test_reset_mid();
        test_big();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/pixel_stream_feeder.md
Name: pixel_stream_feeder

Overview:
- Synthesisable stimulus and result sequencer for the CNN `chip` datapath.
- Holds NUM_IMG images in internal RAM, loaded through a write port, and streams them one pixel per accepted handshake.
- Waits for each classification result, then logs it against the image index.
- Replaces the fixed 784-pixel, no-backpressure feed with parametrised geometry, batch sequencing, backpressure and a result timeout.

Parameters:
DATA_BITS, 8, pixel width
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
NUM_IMG, 4, images per batch (>=1)
CLASS_BITS, 4, decision width
TIMEOUT, 4095, max cycles waiting for a result after the last pixel of an image
ADDR_BITS, $clog2(NUM_IMG*IMG_W*IMG_H), RAM address width
IDX_BITS, $clog2(NUM_IMG)>0 ? $clog2(NUM_IMG) : 1, image index width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  RAM write strobe
wr_addr  in  ADDR_BITS  RAM write address (image k pixel p at k*IMG_W*IMG_H+p)
wr_data  in  DATA_BITS  RAM write data
start  in  1  single-cycle batch start
busy  out  1  high from the start-accept cycle until done
pix_data  out  DATA_BITS  pixel to chip
pix_valid  out  1  pix_data valid
pix_ready  in  1  chip accepts pixel
pix_last  out  1  marks the final pixel of the current image
dec_in  in  CLASS_BITS  chip decision
dec_valid  in  1  chip decision strobe
res_wr  out  1  one-cycle result log strobe
res_idx  out  IDX_BITS  image index of the logged result
res_class  out  CLASS_BITS  logged class; all-ones on timeout
timeout_err  out  1  sticky, set on any timeout, cleared by start
done  out  1  one-cycle pulse after the last result is logged

Behaviour:
- Reset (async, rst_n low):
  - Outputs: busy=0, pix_valid=0, pix_last=0, pix_data=0, res_wr=0, res_idx=0, res_class=0, timeout_err=0, done=0.
  - State=IDLE; all counters=0.
  - RAM contents are not reset.
  - Reset mid-stream aborts the batch with no res_wr or done.
- RAM:
  - Synchronous read, 1-cycle latency.
  - Writes are accepted only in IDLE; wr_en in any other state is ignored.
- FSM states: IDLE, PREFETCH, STREAM, WAIT_RES, LOG, FIN.
  - IDLE: start=1 -> PREFETCH. Clears timeout_err, img=0, pix=0, sets busy. start is ignored outside IDLE.
  - PREFETCH (1 cycle): issues the RAM read for the current pixel. Next cycle -> STREAM with pix_valid=1. First pixel is valid 2 cycles after the start edge.
  - STREAM:
    - A transfer occurs when pix_valid && pix_ready.
    - While pix_valid && !pix_ready, pix_data and pix_last are held stable.
    - The next address is read speculatively, so back-to-back transfers run at 1 pixel/cycle with no bubbles.
    - pix_last=1 when pix==IMG_W*IMG_H-1.
    - On transfer of the last pixel: pix_valid=0 next cycle, pix cleared, wait counter cleared -> WAIT_RES.
  - WAIT_RES: wait counter increments each cycle.
    - dec_valid=1 -> LOG with res_class=dec_in.
    - Counter reaches TIMEOUT without dec_valid -> LOG with res_class=all ones and timeout_err set.
    - If dec_valid and timeout coincide, dec_valid wins.
  - LOG (1 cycle): res_wr=1, res_idx=img.
    - If img==NUM_IMG-1 -> FIN.
    - Otherwise img++ -> PREFETCH.
  - FIN (1 cycle): done=1, busy=0 next cycle -> IDLE.
- Ignored inputs: dec_valid outside WAIT_RES is ignored; no result is logged and no state change occurs.
- Address arithmetic: base = img*IMG_W*IMG_H, computed incrementally (no multiplier). The address wraps only at batch end.
- Minimum latency per image: 1 + IMG_W*IMG_H transfer cycles (pix_ready held high) + result latency + 1 (LOG).

Test Plan (IMG_W=IMG_H=4, NUM_IMG=2, TIMEOUT=20 unless noted):
- Load RAM with pixel value = address (0..31), start, pix_ready=1, dec_valid 5 cycles after each pix_last with dec_in=3 then 7 -> pix_data 0..15 on consecutive cycles with pix_last on 15, then 16..31 with pix_last on 31; res_wr twice with (idx0, class3) then (idx1, class7); done one cycle after the second res_wr.
- Same load, pix_ready toggling 1,0,0,1 repeatedly -> pix_data held during ready=0, every value 0..31 transferred exactly once, in order.
- Never assert dec_valid -> res_class=4'hF logged 20 cycles after each image's last transfer, timeout_err=1 after the first timeout, done still pulses; a new start clears timeout_err.
- Assert start and wr_en mid-STREAM -> no restart, RAM unchanged (checked by re-streaming); dec_valid during STREAM produces no res_wr.
- Deassert rst_n during the pixel-9 stall -> all outputs 0 asynchronously; a fresh start re-streams from pixel 0 of image 0 with the RAM preserved.
- NUM_IMG=1, IMG_W=IMG_H=28 -> exactly 784 transfers, pix_last on the 784th transfer, single res_wr with res_idx=0.
